// File: rtl/paddle_move_scheduler_if.sv
// ============================================================================
// Module : paddle_move_scheduler_if
// Key/frame inputs and paced paddle strobes of the paddle move scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface paddle_move_scheduler_if;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       i_frame_tick;
  logic       o_p1_up;
  logic       o_p1_dn;
  logic       o_p2_up;
  logic       o_p2_dn;
  logic [1:0] o_state;
  logic       o_restart;

  modport master (
    output i_rx_dv, i_rx_byte, i_frame_tick,
    input  o_p1_up, o_p1_dn, o_p2_up, o_p2_dn, o_state, o_restart
  );

  modport slave (
    input  i_rx_dv, i_rx_byte, i_frame_tick,
    output o_p1_up, o_p1_dn, o_p2_up, o_p2_dn, o_state, o_restart
  );
endinterface

`default_nettype wire

// File: rtl/paddle_move_scheduler.sv
// ============================================================================
// Module : paddle_move_scheduler
// Decodes UART key bytes into paddle directions, runs IDLE/RUN/PAUSE and
// emits at most one move strobe per player every MOVE_DIV frames.
// Optional: PADDLE_AUTO_RELEASE_EN adds per-player hold-timeout release.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module paddle_move_scheduler #(
  parameter int unsigned P1_UP       = 119,
  parameter int unsigned P1_DOWN     = 115,
  parameter int unsigned P2_UP       = 105,
  parameter int unsigned P2_DOWN     = 107,
  parameter int unsigned KEY_PAUSE   = 32,
  parameter int unsigned KEY_RESTART = 114,
  parameter int unsigned MOVE_DIV    = 1,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  paddle_move_scheduler_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  localparam logic [7:0] DIV_LAST = 8'(MOVE_DIV - 1);

  if ((MOVE_DIV < 1) || (MOVE_DIV > 255) || (HOLD_FRAMES < 1) || (HOLD_FRAMES > 255)) begin : g_bad_params
    $error("paddle_move_scheduler: MOVE_DIV and HOLD_FRAMES must be in 1..255");
  end

  logic [1:0]       state_q, state_d;
  logic [1:0][1:0]  dir_q, dir_d;
  logic [7:0]       div_q, div_d;
  logic [1:0]       up_q, up_d;
  logic [1:0]       dn_q, dn_d;
  logic             restart_q, restart_d;
`ifdef PADDLE_AUTO_RELEASE_EN
  logic [1:0][7:0]  hold_q, hold_d;
`endif

  logic       is_restart, is_pause, in_run, tick_run, move_frame;
  logic [1:0] key_up, key_dn;

  always_comb begin
    is_restart = bus.i_rx_dv && (bus.i_rx_byte == 8'(KEY_RESTART));
    is_pause   = bus.i_rx_dv && (bus.i_rx_byte == 8'(KEY_PAUSE));
    in_run     = (state_q == ST_RUN);
    key_up[0]  = bus.i_rx_dv && (bus.i_rx_byte == 8'(P1_UP));
    key_dn[0]  = bus.i_rx_dv && (bus.i_rx_byte == 8'(P1_DOWN));
    key_up[1]  = bus.i_rx_dv && (bus.i_rx_byte == 8'(P2_UP));
    key_dn[1]  = bus.i_rx_dv && (bus.i_rx_byte == 8'(P2_DOWN));
    // Restart or pause on a tick cycle suppresses the tick entirely
    tick_run   = bus.i_frame_tick && in_run && !is_restart && !is_pause;
    move_frame = tick_run && (div_q == DIV_LAST);
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    div_d     = div_q;
    up_d      = '0;
    dn_d      = '0;
    restart_d = 1'b0;
`ifdef PADDLE_AUTO_RELEASE_EN
    hold_d    = hold_q;
`endif
    if (is_restart) begin
      state_d   = ST_IDLE;
      dir_d     = '0;
      div_d     = '0;
      restart_d = 1'b1;
`ifdef PADDLE_AUTO_RELEASE_EN
      hold_d    = '0;
`endif
    end else if (is_pause) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN: begin
          state_d = ST_PAUSE;
          dir_d   = '0;
`ifdef PADDLE_AUTO_RELEASE_EN
          hold_d  = '0;
`endif
        end
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end else begin
      if (state_q == ST_IDLE) begin
        div_d = '0;
      end
      if (tick_run) begin
        div_d = move_frame ? 8'd0 : div_q + 8'd1;
      end
      for (int p = 0; p < 2; p++) begin
        // Strobes come from the direction held before this cycle
        up_d[p] = move_frame && (dir_q[p] == DIR_UP);
        dn_d[p] = move_frame && (dir_q[p] == DIR_DN);
`ifdef PADDLE_AUTO_RELEASE_EN
        if (tick_run && (hold_q[p] != 8'd0)) begin
          hold_d[p] = hold_q[p] - 8'd1;
          if (hold_q[p] == 8'd1) begin
            dir_d[p] = DIR_NONE;
          end
        end
`endif
        if (in_run && key_up[p]) begin
          dir_d[p] = DIR_UP;
`ifdef PADDLE_AUTO_RELEASE_EN
          hold_d[p] = 8'(HOLD_FRAMES);
`endif
        end else if (in_run && key_dn[p]) begin
          dir_d[p] = DIR_DN;
`ifdef PADDLE_AUTO_RELEASE_EN
          hold_d[p] = 8'(HOLD_FRAMES);
`endif
        end
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q   <= ST_IDLE;
      dir_q     <= '0;
      div_q     <= '0;
      up_q      <= '0;
      dn_q      <= '0;
      restart_q <= 1'b0;
`ifdef PADDLE_AUTO_RELEASE_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      div_q     <= div_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      restart_q <= restart_d;
`ifdef PADDLE_AUTO_RELEASE_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign bus.o_p1_up   = up_q[0];
  assign bus.o_p1_dn   = dn_q[0];
  assign bus.o_p2_up   = up_q[1];
  assign bus.o_p2_dn   = dn_q[1];
  assign bus.o_state   = state_q;
  assign bus.o_restart = restart_q;

endmodule

`default_nettype wire

// File: tb/tb_paddle_move_scheduler.sv
// ============================================================================
// Module : tb_paddle_move_scheduler
// Bench for paddle_move_scheduler: two instances (MOVE_DIV 1 and 3) share stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_paddle_move_scheduler;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  paddle_move_scheduler_if ifa ();
  paddle_move_scheduler_if ifb ();

  paddle_move_scheduler #(.MOVE_DIV(1), .HOLD_FRAMES(HOLD)) u_a (
    .i_CLK(clk), .i_RST_N(rst_n), .bus(ifa.slave));
  paddle_move_scheduler #(.MOVE_DIV(3), .HOLD_FRAMES(HOLD)) u_b (
    .i_CLK(clk), .i_RST_N(rst_n), .bus(ifb.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: game state as 0/1/2, direction as +1/0/-1, frames counted since start
  int mdiv   [2] = '{1, 3};
  int st     [2];
  int dir    [2][2];
  int frames [2];
  int hold   [2][2];
  logic [6:0] exp_out [2];

  int a_any_obs, b_p2up_obs, b_p2up_exp, a_p2dn_obs;

  logic [7:0] keys [6] = '{8'd119, 8'd115, 8'd105, 8'd107, 8'd32, 8'd114};

  function automatic logic [6:0] obs_a();
    return {ifa.o_p1_up, ifa.o_p1_dn, ifa.o_p2_up, ifa.o_p2_dn, ifa.o_state, ifa.o_restart};
  endfunction

  function automatic logic [6:0] obs_b();
    return {ifb.o_p1_up, ifb.o_p1_dn, ifb.o_p2_up, ifb.o_p2_dn, ifb.o_state, ifb.o_restart};
  endfunction

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_int(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      st[d] = 0;
      frames[d] = 0;
      exp_out[d] = '0;
      for (int p = 0; p < 2; p++) begin
        dir[d][p] = 0;
        hold[d][p] = 0;
      end
    end
  endtask

  task automatic model_step(int d, logic dv, logic [7:0] b, logic tk);
    logic [1:0] up, dn;
    logic rs;
    int upk, dnk;
    up = '0; dn = '0; rs = 1'b0;
    if (dv && b == 8'd114) begin
      st[d] = 0; frames[d] = 0; rs = 1'b1;
      for (int p = 0; p < 2; p++) begin dir[d][p] = 0; hold[d][p] = 0; end
    end else if (dv && b == 8'd32) begin
      if (st[d] == 1) begin
        st[d] = 2;
        for (int p = 0; p < 2; p++) dir[d][p] = 0;
      end else begin
        st[d] = 1;
      end
    end else if (st[d] == 1) begin
      if (tk) begin
        frames[d]++;
        for (int p = 0; p < 2; p++) begin
          if (frames[d] % mdiv[d] == 0) begin
            up[p] = (dir[d][p] == 1);
            dn[p] = (dir[d][p] == -1);
          end
`ifdef PADDLE_AUTO_RELEASE_EN
          if (hold[d][p] > 0) begin
            hold[d][p]--;
            if (hold[d][p] == 0) dir[d][p] = 0;
          end
`endif
        end
      end
      if (dv) begin
        for (int p = 0; p < 2; p++) begin
          upk = (p == 0) ? 119 : 105;
          dnk = (p == 0) ? 115 : 107;
          if (b == 8'(upk)) begin dir[d][p] = 1;  hold[d][p] = HOLD; end
          if (b == 8'(dnk)) begin dir[d][p] = -1; hold[d][p] = HOLD; end
        end
      end
    end
    exp_out[d] = {up[0], dn[0], up[1], dn[1], 2'(st[d]), rs};
  endtask

  task automatic cyc(string tag, logic dv, logic [7:0] b, logic tk);
    ifa.i_rx_dv = dv; ifa.i_rx_byte = b; ifa.i_frame_tick = tk;
    ifb.i_rx_dv = dv; ifb.i_rx_byte = b; ifb.i_frame_tick = tk;
    @(posedge clk);
    #1;
    model_step(0, dv, b, tk);
    model_step(1, dv, b, tk);
    chk({tag, "_a"}, obs_a(), exp_out[0]);
    chk({tag, "_b"}, obs_b(), exp_out[1]);
    a_any_obs  += int'(ifa.o_p1_up) + int'(ifa.o_p1_dn) + int'(ifa.o_p2_up) + int'(ifa.o_p2_dn);
    b_p2up_obs += int'(ifb.o_p2_up);
    b_p2up_exp += int'(exp_out[1][4]);
    a_p2dn_obs += int'(ifa.o_p2_dn);
    ifa.i_rx_dv = 1'b0; ifa.i_frame_tick = 1'b0;
    ifb.i_rx_dv = 1'b0; ifb.i_frame_tick = 1'b0;
  endtask

  task automatic ticks(string tag, int n);
    for (int i = 0; i < n; i++) begin
      cyc(tag, 1'b0, 8'd0, 1'b1);
      cyc(tag, 1'b0, 8'd0, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] rb;
    int r;
    ifa.i_rx_dv = 1'b0; ifa.i_rx_byte = '0; ifa.i_frame_tick = 1'b0;
    ifb.i_rx_dv = 1'b0; ifb.i_rx_byte = '0; ifb.i_frame_tick = 1'b0;
    model_reset();
    a_any_obs = 0; b_p2up_obs = 0; b_p2up_exp = 0; a_p2dn_obs = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", obs_a(), 7'd0);
    chk("reset_b", obs_b(), 7'd0);
    rst_n = 1'b1;

    // Movement keys in IDLE do nothing
    cyc("idle_key", 1'b1, 8'd119, 1'b0);
    ticks("idle_ticks", 10);
    chk_int("idle_no_strobe", a_any_obs, 0);
    chk("idle_state", {5'd0, ifa.o_state}, 7'd0);

    // Start and move player 1 down every frame
    cyc("start", 1'b1, 8'd32, 1'b0);
    cyc("p1_dn_key", 1'b1, 8'd115, 1'b0);
    ticks("p1_dn_run", 3);
    chk("run_state", {5'd0, ifa.o_state}, 7'd1);

    // Divider of 3 with a freshly cleared counter
    cyc("rst_div", 1'b1, 8'd114, 1'b0);
    cyc("start_div", 1'b1, 8'd32, 1'b0);
    cyc("p2_up_key", 1'b1, 8'd105, 1'b0);
    b_p2up_obs = 0; b_p2up_exp = 0;
    ticks("div3", 9);
    chk_int("div3_count", b_p2up_obs, b_p2up_exp);

    // Pause and resume: directions are lost
    cyc("pause", 1'b1, 8'd32, 1'b0);
    chk("pause_state", {5'd0, ifa.o_state}, 7'd2);
    ticks("paused", 5);
    cyc("resume", 1'b1, 8'd32, 1'b0);
    a_any_obs = 0;
    ticks("resumed", 4);
    chk_int("resume_no_strobe", a_any_obs, 0);

    // Restart collides with a move-frame tick
    cyc("p1_up_key", 1'b1, 8'd119, 1'b0);
    cyc("restart_tick", 1'b1, 8'd114, 1'b1);
    chk("restart_pulse", {6'd0, ifa.o_restart}, 7'd1);
    cyc("after_restart", 1'b0, 8'd0, 1'b0);

    // Single key then a long run of frames
    cyc("start_hold", 1'b1, 8'd32, 1'b0);
    cyc("p2_dn_key", 1'b1, 8'd107, 1'b0);
    a_p2dn_obs = 0;
    ticks("hold", 12);
`ifdef PADDLE_AUTO_RELEASE_EN
    chk_int("hold_count", a_p2dn_obs, HOLD);
`else
    chk_int("hold_count", a_p2dn_obs, 12);
`endif

    // Randomized traffic, including key/tick collisions
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 39));
      if (r < 1)       rb = keys[5];
      else if (r < 4)  rb = keys[4];
      else if (r < 30) rb = keys[$urandom_range(0, 3)];
      else             rb = 8'($urandom);
      cyc("rand", ($urandom_range(0, 2) == 0), rb, ($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset in the middle of a cycle
    cyc("pre_areset", 1'b1, 8'd32, 1'b0);
    cyc("pre_areset2", 1'b1, 8'd119, 1'b0);
    ifa.i_frame_tick = 1'b1; ifb.i_frame_tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_a", obs_a(), 7'd0);
    chk("areset_b", obs_b(), 7'd0);
    @(posedge clk);
    #1;
    chk("areset_hold_a", obs_a(), 7'd0);
    ifa.i_frame_tick = 1'b0; ifb.i_frame_tick = 1'b0;
    rst_n = 1'b1;
    model_reset();
    ticks("post_areset", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
